hazard_ctrl_unit: RTL and testbench

Parametrised hazard and pipeline-control unit for the 5-stage RV32I core. It sits beside the fetch/decode/execute/memory/writeback stages and drives several signals:
- operand forwarding selects into execute;
- fetch/decode stall enables;
- decode/execute flushes.

It generalises plain M/W forwarding with a sequential load-use stall FSM whose bubble length is set by LOAD_LAT (multi-cycle data memory). It also provides taken-branch/jump flush with stall abort, and optional performance counters.

---
 rtl/hazard_ctrl_unit.sv | 140 ++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// Hazard/pipeline control for the 5-stage RV32I core: M/W forwarding, load-use stall FSM, redirect flush.
// Define HZ_PERF_CNT_EN to build the saturating stall/flush performance counters.
module hazard_ctrl_unit #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1_D,
    input  logic [REG_AW-1:0] Rs2_D,
    input  logic [REG_AW-1:0] Rs1_E,
    input  logic [REG_AW-1:0] Rs2_E,
    input  logic [REG_AW-1:0] RD_E,
    input  logic [1:0]        ResultSrcE,
    input  logic [REG_AW-1:0] RD_M,
    input  logic              RegWriteM,
    input  logic [REG_AW-1:0] RD_W,
    input  logic              RegWriteW,
    input  logic              PCSrcE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [3:0] HOLD_INIT = 4'(LOAD_LAT - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       lw_hit;
    logic       stall;
    logic       redirect;

    // Everything is qualified by rst so outputs read zero for the whole reset window.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if (RegWriteM && RD_M != '0 && RD_M == rs)
            return 2'b10;
        else if (RegWriteW && RD_W != '0 && RD_W == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (rst) begin
            ForwardAE = fwd_sel(Rs1_E);
            ForwardBE = fwd_sel(Rs2_E);
        end
    end

    assign redirect = rst && PCSrcE;
    assign lw_hit   = rst && (ResultSrcE == 2'b01) && (RD_E != '0) &&
                      (RD_E == Rs1_D || RD_E == Rs2_D) &&
                      (state_q == IDLE) && !PCSrcE;
    assign stall    = lw_hit || (state_q == HOLD);

    assign StallF = stall;
    assign StallD = stall;
    assign FlushD = redirect;
    assign FlushE = stall || redirect;

    // The hit cycle is the first bubble; HOLD covers the remaining LOAD_LAT-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (lw_hit && LOAD_LAT > 1) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_INIT;
                end
            end
            HOLD: begin
                if (PCSrcE || cnt_q == 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HZ_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturate rather than wrap so long runs stay meaningful.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        if (PCSrcE && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench: three hazard_ctrl_unit instances (LOAD_LAT 1/3/4) against a remaining-bubble model.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0] rse;
    logic       rwm, rww, pc;

    logic [1:0]  fa[3], fb[3];
    logic        sf[3], sd[3], fdd[3], fe[3];
    logic [15:0] sc[3], fc[3];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 4;
        localparam int CW  = (g == 2) ? 4 : 16;
        logic [CW-1:0] scw, fcw;
        hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(LAT), .CNT_W(CW)) u_dut (
            .clk(clk), .rst(rst),
            .Rs1_D(rs1d), .Rs2_D(rs2d), .Rs1_E(rs1e), .Rs2_E(rs2e),
            .RD_E(rde), .ResultSrcE(rse), .RD_M(rdm), .RegWriteM(rwm),
            .RD_W(rdw), .RegWriteW(rww), .PCSrcE(pc),
            .ForwardAE(fa[g]), .ForwardBE(fb[g]), .StallF(sf[g]), .StallD(sd[g]),
            .FlushD(fdd[g]), .FlushE(fe[g]), .stall_cnt(scw), .flush_cnt(fcw)
        );
        assign sc[g] = 16'(scw);
        assign fc[g] = 16'(fcw);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d expected=%0d t=%0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: remaining bubble cycles per instance plus event tallies.
    int LATV[3] = '{1, 3, 4};
    int MAXV[3] = '{65535, 65535, 15};
    int rem[3]  = '{0, 0, 0};
    int msc[3]  = '{0, 0, 0};
    int mfc[3]  = '{0, 0, 0};

    function automatic logic [1:0] mfwd(input logic [4:0] rs);
        if (rwm && rdm != 0 && rdm == rs) return 2'd2;
        if (rww && rdw != 0 && rdw == rs) return 2'd1;
        return 2'd0;
    endfunction

    always @(negedge clk) begin : model
        logic [1:0] ea, eb;
        logic       hit, st, pcx;
        int         esc, efc;
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                rem[i] = 0; msc[i] = 0; mfc[i] = 0;
                ea = 0; eb = 0; st = 0; pcx = 0; hit = 0;
            end else begin
                ea  = mfwd(rs1e);
                eb  = mfwd(rs2e);
                pcx = pc;
                hit = (rse == 2'd1) && rde != 0 && (rde == rs1d || rde == rs2d) && rem[i] == 0 && !pc;
                st  = hit || rem[i] > 0;
            end
`ifdef HZ_PERF_CNT_EN
            esc = msc[i]; efc = mfc[i];
`else
            esc = 0; efc = 0;
`endif
            if (fa[i] !== ea)  chk($sformatf("m%0d_fwdA", i), 32'(fa[i]), 32'(ea)); else checks++;
            if (fb[i] !== eb)  chk($sformatf("m%0d_fwdB", i), 32'(fb[i]), 32'(eb)); else checks++;
            if (sf[i] !== st)  chk($sformatf("m%0d_stallF", i), 32'(sf[i]), 32'(st)); else checks++;
            if (sd[i] !== st)  chk($sformatf("m%0d_stallD", i), 32'(sd[i]), 32'(st)); else checks++;
            if (fdd[i] !== pcx) chk($sformatf("m%0d_flushD", i), 32'(fdd[i]), 32'(pcx)); else checks++;
            if (fe[i] !== (st | pcx)) chk($sformatf("m%0d_flushE", i), 32'(fe[i]), 32'(st | pcx)); else checks++;
            if (sc[i] !== 16'(esc)) chk($sformatf("m%0d_stall_cnt", i), 32'(sc[i]), 32'(esc)); else checks++;
            if (fc[i] !== 16'(efc)) chk($sformatf("m%0d_flush_cnt", i), 32'(fc[i]), 32'(efc)); else checks++;
            if (rst) begin
                if (st && msc[i] < MAXV[i]) msc[i]++;
                if (pc && mfc[i] < MAXV[i]) mfc[i]++;
                if (hit)         rem[i] = LATV[i] - 1;
                else if (pc)     rem[i] = 0;
                else if (rem[i] > 0) rem[i]--;
            end
        end
    end

    task automatic clr();
        rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
        rse = 0; rwm = 0; rww = 0; pc = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use();
        rse = 2'b01; rde = 5'd7; rs2d = 5'd7;
    endtask

    initial begin
        clr();
        rst = 1'b0;
        rdm = 5'd5; rwm = 1'b1; rs1e = 5'd5; pc = 1'b1;
        load_use();
        #1;
        chk("reset_fwdA", 32'(fa[0]), 0);
        chk("reset_flushD", 32'(fdd[1]), 0);
        chk("reset_flushE", 32'(fe[2]), 0);
        chk("reset_stallF", 32'(sf[0]), 0);
        step(); step();
        clr(); rst = 1'b1;

        // forwarding priority
        step();
        rdm = 5; rwm = 1; rdw = 5; rww = 1; rs1e = 5; rs2e = 5;
        #2; chk("fwd_mem_prio_A", 32'(fa[0]), 2); chk("fwd_mem_prio_B", 32'(fb[0]), 2);
        step(); rwm = 0;
        #2; chk("fwd_wb_A", 32'(fa[0]), 1);
        step(); rs1e = 0; rdm = 0; rdw = 0;
        #2; chk("fwd_none_A", 32'(fa[0]), 0);
        step(); clr();

        // single load-use hazard seen by all three latencies
        step(); load_use();
        #2;
        chk("lu1_stallF", 32'(sf[0]), 1); chk("lu1_flushE", 32'(fe[0]), 1);
        chk("lu1_flushD", 32'(fdd[0]), 0); chk("lu3_c1", 32'(sf[1]), 1);
        step(); clr();
        #2; chk("lu1_done", 32'(sf[0]), 0); chk("lu3_c2", 32'(sf[1]), 1); chk("lu4_c2", 32'(sf[2]), 1);
        step();
        #2; chk("lu3_c3", 32'(sd[1]), 1); chk("lu4_c3", 32'(sf[2]), 1);
        step();
        #2; chk("lu3_done", 32'(sf[1]), 0); chk("lu4_c4", 32'(sf[2]), 1);
        step();
        #2; chk("lu4_done", 32'(sf[2]), 0);
`ifdef HZ_PERF_CNT_EN
        chk("lu3_stall_cnt", 32'(sc[1]), 3); chk("lu4_stall_cnt", 32'(sc[2]), 4);
`endif

        // branch overrides load-use
        step(); load_use(); pc = 1;
        #2; chk("br_stallF", 32'(sf[1]), 0); chk("br_flushD", 32'(fdd[1]), 1); chk("br_flushE", 32'(fe[1]), 1);
        step(); clr();
        #2; chk("br_no_fsm", 32'(sf[1]), 0);

        // reset in the 2nd stall cycle of LOAD_LAT=4
        step(); load_use();
        #2; chk("rst_hold_c1", 32'(sf[2]), 1);
        step(); clr(); rdm = 5; rwm = 1; rs1e = 5; pc = 1;
        #2; chk("rst_hold_c2", 32'(sf[2]), 1);
        rst = 1'b0;
        #1; chk("rst_async_stall", 32'(sf[2]), 0); chk("rst_async_fwd", 32'(fa[2]), 0);
        chk("rst_async_flushE", 32'(fe[2]), 0);
        step(); clr();
        step(); rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #2; chk("rst_no_stall", 32'(sf[2]), 0);
            step();
        end

        // redirect counter saturation
        pc = 1;
        for (int k = 0; k < 20; k++) step();
        pc = 0;
        #2;
`ifdef HZ_PERF_CNT_EN
        chk("sat_flush_cnt4", 32'(fc[2]), 15); chk("flush_cnt16", 32'(fc[1]), 20);
`endif
        step(); step();
`ifdef HZ_PERF_CNT_EN
        chk("sat_hold", 32'(fc[2]), 15);
`endif

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            step();
            rs1d = 5'($urandom_range(0, 3)); rs2d = 5'($urandom_range(0, 3));
            rs1e = 5'($urandom_range(0, 3)); rs2e = 5'($urandom_range(0, 3));
            rde  = 5'($urandom_range(0, 3)); rdm  = 5'($urandom_range(0, 3));
            rdw  = 5'($urandom_range(0, 3)); rse  = 2'($urandom_range(0, 3));
            rwm  = 1'($urandom_range(0, 1)); rww  = 1'($urandom_range(0, 1));
            pc   = ($urandom_range(0, 7) == 0);
            rst  = ($urandom_range(0, 99) != 0);
        end
        step(); rst = 1'b1; clr();
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
